// File: rtl/sarray_rd_arb.sv
// Two-requester read arbiter onto one memory port, with an in-order outstanding-ID FIFO that routes returning data.
// Optional build macro: SARRAY_RD_ARB_FIXED_PRIO_EN (requester 0 always wins; no round-robin pointer).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif

module sarray_rd_arb #(
  parameter int unsigned OSTD_DEPTH = 8,
  parameter int unsigned OSTD_CNT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s0_ar_valid_i,
  output logic                          s0_ar_ready_o,
  input  logic [`ADDR_WIDTH-1:0]        s0_ar_addr_i,
  output logic                          s0_r_valid_o,
  input  logic                          s0_r_ready_i,
  output logic [`SARRAY_LOAD_WIDTH-1:0] s0_r_data_o,
  input  logic                          s1_ar_valid_i,
  output logic                          s1_ar_ready_o,
  input  logic [`ADDR_WIDTH-1:0]        s1_ar_addr_i,
  output logic                          s1_r_valid_o,
  input  logic                          s1_r_ready_i,
  output logic [`SARRAY_LOAD_WIDTH-1:0] s1_r_data_o,
  output logic                          m_ar_valid_o,
  input  logic                          m_ar_ready_i,
  output logic [`ADDR_WIDTH-1:0]        m_ar_addr_o,
  input  logic                          m_r_valid_i,
  output logic                          m_r_ready_o,
  input  logic [`SARRAY_LOAD_WIDTH-1:0] m_r_data_i,
  output logic [OSTD_CNT_W-1:0]         ostd_cnt_o
);

  localparam int unsigned PTR_W = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;

  logic                   ar_vld_q, ar_vld_d;
  logic [`ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OSTD_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   id_mem_q [OSTD_DEPTH];

  logic ar_free, fifo_full, fifo_empty, any_req, grant, win;
  logic push, pop, head_id, route_en;

`ifndef SARRAY_RD_ARB_FIXED_PRIO_EN
  logic rr_last_q, rr_last_d;
`endif

  // Arbitration and grant qualification
  always_comb begin
    ar_free    = !ar_vld_q || m_ar_ready_i;
    fifo_full  = (cnt_q == OSTD_CNT_W'(OSTD_DEPTH));
    fifo_empty = (cnt_q == '0);
    any_req    = s0_ar_valid_i || s1_ar_valid_i;
`ifdef SARRAY_RD_ARB_FIXED_PRIO_EN
    win        = !s0_ar_valid_i;
`else
    win        = (s0_ar_valid_i && s1_ar_valid_i) ? !rr_last_q : !s0_ar_valid_i;
`endif
    // Full blocks the grant even when a pop lands in the same cycle.
    grant      = !rst && ar_free && !fifo_full && any_req;
    push       = grant;
  end

  assign s0_ar_ready_o = grant && !win;
  assign s1_ar_ready_o = grant &&  win;
  assign m_ar_valid_o  = ar_vld_q;
  assign m_ar_addr_o   = ar_addr_q;

  // Read-data routing from the FIFO head
  always_comb begin
    head_id      = id_mem_q[rd_ptr_q];
    route_en     = !fifo_empty && !rst;
    m_r_ready_o  = route_en && (head_id ? s1_r_ready_i : s0_r_ready_i);
    s0_r_valid_o = route_en && !head_id && m_r_valid_i;
    s1_r_valid_o = route_en &&  head_id && m_r_valid_i;
    s0_r_data_o  = m_r_data_i;
    s1_r_data_o  = m_r_data_i;
    pop          = m_r_valid_i && m_r_ready_o;
  end

  assign ostd_cnt_o = cnt_q;

  always_comb begin
    ar_vld_d  = ar_vld_q;
    ar_addr_d = ar_addr_q;
    if (grant) begin
      ar_vld_d  = 1'b1;
      ar_addr_d = win ? s1_ar_addr_i : s0_ar_addr_i;
    end else if (ar_vld_q && m_ar_ready_i) begin
      ar_vld_d  = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

`ifndef SARRAY_RD_ARB_FIXED_PRIO_EN
    rr_last_d = grant ? win : rr_last_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
`ifndef SARRAY_RD_ARB_FIXED_PRIO_EN
      // Last grant looks like requester 1, so requester 0 wins the first tie.
      rr_last_q <= 1'b1;
`endif
    end else begin
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
`ifndef SARRAY_RD_ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= win;
  end

endmodule

// File: tb/tb_sarray_rd_arb.sv
// Scoreboard bench for sarray_rd_arb: AR addresses and requester IDs are queued on grant and checked at the memory AR and R ports.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 64
`endif

module tb_sarray_rd_arb;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef logic [`ADDR_WIDTH-1:0]        addr_t;
  typedef logic [`SARRAY_LOAD_WIDTH-1:0] data_t;

  logic clk, rst;
  logic s0_ar_valid_i, s0_ar_ready_o, s0_r_valid_o, s0_r_ready_i;
  logic s1_ar_valid_i, s1_ar_ready_o, s1_r_valid_o, s1_r_ready_i;
  addr_t s0_ar_addr_i, s1_ar_addr_i, m_ar_addr_o;
  data_t s0_r_data_o, s1_r_data_o, m_r_data_i;
  logic m_ar_valid_o, m_ar_ready_i, m_r_valid_i, m_r_ready_o;
  logic [CNT_W-1:0] ostd_cnt_o;

  sarray_rd_arb #(.OSTD_DEPTH(DEPTH), .OSTD_CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_ar_valid_i(s0_ar_valid_i), .s0_ar_ready_o(s0_ar_ready_o), .s0_ar_addr_i(s0_ar_addr_i),
    .s0_r_valid_o(s0_r_valid_o), .s0_r_ready_i(s0_r_ready_i), .s0_r_data_o(s0_r_data_o),
    .s1_ar_valid_i(s1_ar_valid_i), .s1_ar_ready_o(s1_ar_ready_o), .s1_ar_addr_i(s1_ar_addr_i),
    .s1_r_valid_o(s1_r_valid_o), .s1_r_ready_i(s1_r_ready_i), .s1_r_data_o(s1_r_data_o),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_addr_o(m_ar_addr_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_data_i(m_r_data_i),
    .ostd_cnt_o(ostd_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Scoreboard state
  addr_t       ar_q[$];
  bit          id_q[$];
  int unsigned mdl_cnt = 0;
  bit          rr_last = 1'b1;
  bit          in_rst  = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_winner(input bit v0, input bit v1);
`ifdef SARRAY_RD_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return !rr_last;
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive at posedge+1, check at negedge, update scoreboard after the edge.
  task automatic cyc(input bit v0, input addr_t a0, input bit v1, input addr_t a1, input bit mrdy,
                     input bit rv, input data_t rd, input bit rr0, input bit rr1);
    bit gnt, w, free, head, pop;
    rst           = in_rst;
    s0_ar_valid_i = v0;  s0_ar_addr_i = a0;
    s1_ar_valid_i = v1;  s1_ar_addr_i = a1;
    m_ar_ready_i  = mrdy;
    m_r_valid_i   = rv;  m_r_data_i   = rd;
    s0_r_ready_i  = rr0; s1_r_ready_i = rr1;
    #4;
    free = (ar_q.size() == 0) || mrdy;
    gnt  = !in_rst && free && (mdl_cnt < DEPTH) && (v0 || v1);
    w    = exp_winner(v0, v1);
    chk("s0_ar_ready", s0_ar_ready_o, gnt && !w);
    chk("s1_ar_ready", s1_ar_ready_o, gnt && w);
    chk("m_ar_valid", m_ar_valid_o, ar_q.size() != 0);
    if (ar_q.size() != 0) chk("m_ar_addr", m_ar_addr_o, ar_q[0]);
    pop = 1'b0;
    if (id_q.size() == 0) begin
      chk("m_r_ready_empty", m_r_ready_o, 1'b0);
      chk("s0_r_valid_empty", s0_r_valid_o, 1'b0);
      chk("s1_r_valid_empty", s1_r_valid_o, 1'b0);
    end else begin
      head = id_q[0];
      chk("s0_r_valid", s0_r_valid_o, rv && !head);
      chk("s1_r_valid", s1_r_valid_o, rv && head);
      chk("m_r_ready", m_r_ready_o, head ? rr1 : rr0);
      if (rv) chk(head ? "s1_r_data" : "s0_r_data", head ? s1_r_data_o : s0_r_data_o, rd);
      pop = rv && (head ? rr1 : rr0);
    end
    chk("ostd_cnt", ostd_cnt_o, mdl_cnt);
    tick();
    if (!in_rst) begin
      if (ar_q.size() != 0 && mrdy) void'(ar_q.pop_front());
      if (pop) begin
        void'(id_q.pop_front());
        mdl_cnt--;
      end
      if (gnt) begin
        ar_q.push_back(w ? a1 : a0);
        id_q.push_back(w);
        mdl_cnt++;
        rr_last = w;
      end
    end
  endtask

  task automatic idle(input bit mrdy);
    cyc(1'b0, '0, 1'b0, '0, mrdy, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic rbeat(input data_t d);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, d, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    rst    = 1'b1;
    ar_q.delete();
    id_q.delete();
    mdl_cnt = 0;
    rr_last = 1'b1;
    tick();
    // Requests and an R beat presented during reset must see no handshake.
    cyc(1'b1, 'h55, 1'b1, 'h66, 1'b1, 1'b1, 'h77, 1'b1, 1'b1);
    chk("rst_m_ar_addr", m_ar_addr_o, '0);
    chk("rst_ostd", ostd_cnt_o, '0);
    in_rst = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s0_ar_valid_i = 0; s1_ar_valid_i = 0; s0_ar_addr_i = '0; s1_ar_addr_i = '0;
    s0_r_ready_i = 0; s1_r_ready_i = 0; m_ar_ready_i = 0; m_r_valid_i = 0; m_r_data_i = '0;
    tick();
    do_reset();

    // Both requesters continuously valid: alternating grants, address 1 cycle later
    for (int i = 0; i < 4; i++)
      cyc(1'b1, addr_t'(32'h100 + i), 1'b1, addr_t'(32'h200 + i), 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    chk("ostd_after_4", ostd_cnt_o, 4);
    for (int i = 0; i < 4; i++) rbeat(data_t'(32'hD0 + i));

    // Memory AR stalled: register holds, no further grants, one push
    cyc(1'b1, 'h300, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, addr_t'(32'h301 + i), 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stall_ostd", ostd_cnt_o, 1);
    idle(1'b1);
    rbeat('hE0);

    // Fill to DEPTH, then full blocks the grant in the pop cycle
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, addr_t'(32'h500 + i), 1'b1, addr_t'(32'h600 + i), 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 'h5F0, 1'b1, 'h6F0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("full_ostd", ostd_cnt_o, DEPTH);
    cyc(1'b1, 'h5F1, 1'b1, 'h6F1, 1'b1, 1'b1, 'hF0, 1'b1, 1'b1);
    cyc(1'b1, 'h5F2, 1'b1, 'h6F2, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    for (int i = 0; i < DEPTH; i++) rbeat(data_t'(32'hF1 + i));
    chk("drained_ostd", ostd_cnt_o, 0);

    // Ordered return s0,s1,s0 with a stall on s1
    cyc(1'b1, 'h400, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 'h410, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 'h420, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    rbeat('hA);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 'hB, 1'b1, 1'b0);
    rbeat('hB);
    rbeat('hC);

    // R beat with nothing outstanding is not accepted
    rbeat('hDEAD);
    chk("empty_ostd", ostd_cnt_o, 0);

    // Mid-operation reset discards pending AR and outstanding IDs
    for (int i = 0; i < 3; i++)
      cyc(1'b1, addr_t'(32'h700 + i), 1'b1, addr_t'(32'h800 + i), 1'b0, 1'b0, '0, 1'b1, 1'b1);
    do_reset();
    cyc(1'b1, 'h900, 1'b1, 'hA00, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 'h901, 1'b1, 'hA01, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    rbeat('h11);
    rbeat('h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sarray_rd_arb.md
SARRAY_RD_ARB -- requirements
Module: sarray_rd_arb

Interface
REQ-001 SHALL have parameter OSTD_DEPTH, default 8, meaning the maximum number of accepted-but-unreturned reads (power of two, 2..32).
REQ-002 SHALL have parameter OSTD_CNT_W, default 4, meaning the width of ostd_cnt_o; it SHALL be log2(OSTD_DEPTH)+1.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports s0_ar_valid_i/s0_ar_ready_o  in/out  1  read-address handshake, requester 0 (systolic-array load path).
REQ-006 SHALL have port s0_ar_addr_i  input  `ADDR_WIDTH  read address, requester 0.
REQ-007 SHALL have ports s0_r_valid_o/s0_r_ready_i  out/in  1  read-data handshake, requester 0.
REQ-008 SHALL have port s0_r_data_o  output  `SARRAY_LOAD_WIDTH  read data, requester 0.
REQ-009 SHALL have ports s1_ar_*, s1_r_*  same directions and widths as REQ-005..008  requester 1 (vector load path).
REQ-010 SHALL have ports m_ar_valid_o/m_ar_ready_i  out/in  1  read-address handshake, shared memory port.
REQ-011 SHALL have port m_ar_addr_o  output  `ADDR_WIDTH  read address, shared memory port.
REQ-012 SHALL have ports m_r_valid_i/m_r_ready_o  in/out  1  read-data handshake, shared memory port.
REQ-013 SHALL have port m_r_data_i  input  `SARRAY_LOAD_WIDTH  read data, shared memory port.
REQ-014 SHALL have port ostd_cnt_o  output  OSTD_CNT_W  current outstanding-read count.

Function
REQ-015 AR path SHALL be a single output register (valid, addr); m_ar_valid_o and m_ar_addr_o SHALL be driven only from that register.
REQ-016 The output register SHALL be "free" in a cycle when it is empty, or when m_ar_valid_o & m_ar_ready_i.
REQ-017 Each cycle the arbiter SHALL pick a winner among valid requesters.
REQ-018 Winner selection SHALL be round-robin: the requester after the last granted one has priority; the pointer advances only on a grant.
REQ-019 A grant SHALL occur when the register is free, the outstanding FIFO is not full, and at least one requester is valid.
REQ-020 sN_ar_ready_o SHALL be 1 only for the granted requester in a grant cycle; it SHALL be 0 otherwise.
REQ-021 On a grant, the register SHALL load the winner's address, and the winner's ID (0/1) SHALL be pushed into the outstanding FIFO in the same cycle.
REQ-022 Latency from sN_ar handshake to m_ar_valid_o SHALL be exactly 1 cycle.
REQ-023 m_ar_valid_o and m_ar_addr_o SHALL stay stable while m_ar_ready_i=0.
REQ-024 Back-to-back grants SHALL be possible every cycle while m_ar_ready_i=1.
REQ-025 Reads SHALL return in order; the FIFO head ID SHALL route data.
REQ-026 When the FIFO is non-empty: s[head]_r_valid_o = m_r_valid_i, s[head]_r_data_o = m_r_data_i, m_r_ready_o = s[head]_r_ready_i (combinational).
REQ-027 The non-head requester's r_valid SHALL be 0.
REQ-028 When the FIFO is empty, m_r_ready_o SHALL be 0 and both sN_r_valid_o SHALL be 0.
REQ-029 An R beat arriving with the FIFO empty SHALL NOT be accepted.
REQ-030 A pop SHALL occur on m_r_valid_i & m_r_ready_o.
REQ-031 Full FIFO: a grant SHALL be blocked even if a pop occurs in the same cycle (no full-cycle bypass).
REQ-032 Simultaneous push and pop when the FIFO is not full SHALL leave the count unchanged.
REQ-033 Count SHALL equal pushes minus pops and SHALL never exceed OSTD_DEPTH; FIFO pointers SHALL wrap modulo OSTD_DEPTH.
REQ-034 ostd_cnt_o SHALL show the registered count.

Reset
REQ-035 While rst=1, at the next edge: AR register empty (m_ar_valid_o=0, m_ar_addr_o=0), FIFO empty (pointers 0, ostd_cnt_o=0), round-robin pointer set so requester 0 wins the first tie.
REQ-036 During and after reset, all sN_ar_ready_o, sN_r_valid_o and m_r_ready_o SHALL be 0 until the conditions above assert them.
REQ-037 Reset mid-operation SHALL discard pending AR and outstanding IDs; the system SHALL reset the memory side together with this block.

Configuration
REQ-038 With macro SARRAY_RD_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when valid, and the round-robin pointer SHALL be removed.
REQ-039 Without SARRAY_RD_ARB_FIXED_PRIO_EN, round-robin per REQ-018 SHALL apply.

Verification
REQ-040 Reset then both ar_valid=1 continuously, m_ar_ready=1 -> grants alternate 0,1,0,1; m_ar_addr follows 1 cycle later.
REQ-041 s0 only, m_ar_ready=0 for 3 cycles -> m_ar_addr constant, s0_ar_ready=0 after first grant, one push, ostd_cnt=1.
REQ-042 8 grants with m_r_valid=0 -> ostd_cnt=8, further ar_ready=0; one R beat pops -> ar_ready still 0 that cycle, grant next cycle.
REQ-043 Order s0,s1,s0 with R data 0xA,0xB,0xC -> s0 gets 0xA, s1 gets 0xB, s0 gets 0xC; s1_r_ready=0 stalls 0xB with m_r_ready=0.
REQ-044 m_r_valid=1 with FIFO empty -> m_r_ready=0, no sN_r_valid; with SARRAY_RD_ARB_FIXED_PRIO_EN and both valid -> s0 granted every cycle.
